// File: rtl/adc_seq_ctrl.sv
// adc_seq_ctrl: conversion sequencer for the FRIDA ADC array.
//
// It generates the INIT/SAMP/COMP/UPDATE phase strobes for N_ADC converters.
// Each phase length is programmable. The block captures N_BITS comparator
// decisions per enabled channel. It then drains {channel, word} results
// through a small FIFO with a valid/ready handshake.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   cfg_t_*             phase lengths in cycles (0 behaves as 1)
//   cfg_en              channel enable mask
//   cfg_mode            0 = single conversion, 1 = continuous
//   start, abort        start request (IDLE only), terminate activity
//   comp_in             comparator decisions, one per ADC
//   seq_*               registered phase strobes
//   busy, done          not-IDLE flag, completion pulse (last DRAIN cycle)
//   res_valid/ready     result handshake; res_chan/res_data = FIFO head

// Per-channel decision shift register.
module adc_seq_lane #(
    parameter int N_BITS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_cap,
    input  logic              i_comp,
    output logic [N_BITS-1:0] o_word
);
    logic [N_BITS-1:0] r_word;

    generate
        if (N_BITS == 1) begin : g_one
            always_ff @(posedge clk or posedge rst) begin
                if (rst)        r_word <= '0;
                else if (i_clr) r_word <= '0;
                else if (i_cap) r_word <= i_comp;
            end
        end else begin : g_multi
            // First decision shifts up to the MSB.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)        r_word <= '0;
                else if (i_clr) r_word <= '0;
                else if (i_cap) r_word <= {r_word[N_BITS-2:0], i_comp};
            end
        end
    endgenerate

    assign o_word = r_word;
endmodule

module adc_seq_ctrl #(
    parameter int N_ADC      = 16,
    parameter int N_BITS     = 16,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CH_W       = $clog2(N_ADC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  cfg_t_init,
    input  logic [CNT_W-1:0]  cfg_t_samp,
    input  logic [CNT_W-1:0]  cfg_t_comp,
    input  logic [CNT_W-1:0]  cfg_t_update,
    input  logic [N_ADC-1:0]  cfg_en,
    input  logic              cfg_mode,
    input  logic              start,
    input  logic              abort,
    input  logic [N_ADC-1:0]  comp_in,
    output logic              seq_init,
    output logic              seq_samp,
    output logic              seq_cmp,
    output logic              seq_logic,
    output logic              busy,
    output logic              done,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CH_W-1:0]   res_chan,
    output logic [N_BITS-1:0] res_data
);
    localparam int BIT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int EW    = CH_W + N_BITS;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_SAMP, S_COMP, S_UPDATE, S_DRAIN
    } state_t;

    state_t r_state, w_next;

    logic [CNT_W-1:0] r_t_init, r_t_samp, r_t_comp, r_t_upd;
    logic [N_ADC-1:0] r_en;
    logic             r_mode;
    logic [CNT_W-1:0] r_cnt, w_len;
    logic [BIT_W-1:0] r_bit;
    logic [CH_W-1:0]  r_ptr;
    logic             w_last, w_latch, w_cap, w_push_req, w_ptr_adv, w_done;
    logic             r_seq_init, r_seq_samp, r_seq_cmp, r_seq_logic, r_busy;

    logic [N_ADC-1:0][N_BITS-1:0] w_word;

    logic [EW-1:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [AW:0]      r_count;
    logic             w_full, w_push, w_pop;
    logic [EW-1:0]    w_head, w_push_data;

    // Length of the current phase; a programmed 0 still lasts one cycle.
    always_comb begin
        w_len = r_t_init;
        case (r_state)
            S_SAMP:   w_len = r_t_samp;
            S_COMP:   w_len = r_t_comp;
            S_UPDATE: w_len = r_t_upd;
            default:  w_len = r_t_init;
        endcase
    end
    assign w_last = (w_len == '0) || (r_cnt == w_len - CNT_W'(1));

    always_comb begin
        w_next     = r_state;
        w_latch    = 1'b0;
        w_cap      = 1'b0;
        w_push_req = 1'b0;
        w_ptr_adv  = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && (cfg_en != '0)) begin
                    w_next  = S_INIT;
                    w_latch = 1'b1;
                end
            end
            S_INIT:   if (w_last) w_next = S_SAMP;
            S_SAMP:   if (w_last) w_next = S_COMP;
            S_COMP: begin
                w_cap = w_last;
                if (w_last) w_next = S_UPDATE;
            end
            S_UPDATE: begin
                if (w_last)
                    w_next = (r_bit == BIT_W'(N_BITS - 1)) ? S_DRAIN : S_COMP;
            end
            S_DRAIN: begin
                // Enabled channels wait for FIFO room; disabled ones skip.
                if (r_en[r_ptr]) begin
                    w_push_req = 1'b1;
                    w_ptr_adv  = ~w_full;
                end else begin
                    w_ptr_adv  = 1'b1;
                end
                if (w_ptr_adv && (r_ptr == CH_W'(N_ADC - 1))) begin
                    w_done = 1'b1;
                    // Continue only while the live mode bit is still set, so
                    // clearing cfg_mode stops after the drain in progress.
                    if (r_mode && cfg_mode) begin
                        w_next  = S_INIT;
                        w_latch = 1'b1;
                    end else begin
                        w_next  = S_IDLE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE)) begin
            w_next     = S_IDLE;
            w_latch    = 1'b0;
            w_cap      = 1'b0;
            w_push_req = 1'b0;
            w_ptr_adv  = 1'b0;
            w_done     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_ptr       <= '0;
            r_t_init    <= '0;
            r_t_samp    <= '0;
            r_t_comp    <= '0;
            r_t_upd     <= '0;
            r_en        <= '0;
            r_mode      <= 1'b0;
            r_seq_init  <= 1'b0;
            r_seq_samp  <= 1'b0;
            r_seq_cmp   <= 1'b0;
            r_seq_logic <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
            if (w_latch) begin
                r_t_init <= cfg_t_init;
                r_t_samp <= cfg_t_samp;
                r_t_comp <= cfg_t_comp;
                r_t_upd  <= cfg_t_update;
                r_en     <= cfg_en;
                r_mode   <= cfg_mode;
                r_bit    <= '0;
            end else if ((r_state == S_UPDATE) && (w_next == S_COMP)) begin
                r_bit <= r_bit + BIT_W'(1);
            end
            if ((w_next == S_DRAIN) && (r_state != S_DRAIN)) r_ptr <= '0;
            else if (w_ptr_adv)                             r_ptr <= r_ptr + CH_W'(1);
            // Strobes come from the next state so they change on the edge.
            r_seq_init  <= (w_next == S_INIT);
            r_seq_samp  <= (w_next == S_SAMP);
            r_seq_cmp   <= (w_next == S_COMP);
            r_seq_logic <= (w_next == S_UPDATE);
            r_busy      <= (w_next != S_IDLE);
        end
    end

    generate
        for (genvar i = 0; i < N_ADC; i++) begin : g_lane
            adc_seq_lane #(.N_BITS(N_BITS)) u_lane (
                .clk    (clk),
                .rst    (rst),
                .i_clr  (w_latch),
                .i_cap  (w_cap & r_en[i]),
                .i_comp (comp_in[i]),
                .o_word (w_word[i])
            );
        end
    endgenerate

    // Result FIFO; push is gated by the pre-pop full flag.
    assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_push      = w_push_req & ~w_full;
    assign res_valid   = (r_count != '0);
    assign w_pop       = res_valid & res_ready;
    assign w_push_data = {r_ptr, w_word[r_ptr]};
    assign w_head      = r_mem[r_rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) r_mem[k] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= w_push_data;
                r_wp        <= r_wp + AW'(1);
            end
            if (w_pop) r_rp <= r_rp + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign res_chan  = res_valid ? w_head[EW-1:N_BITS] : '0;
    assign res_data  = res_valid ? w_head[N_BITS-1:0]  : '0;
    assign seq_init  = r_seq_init;
    assign seq_samp  = r_seq_samp;
    assign seq_cmp   = r_seq_cmp;
    assign seq_logic = r_seq_logic;
    assign busy      = r_busy;
    assign done      = w_done;
endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Directed bench for adc_seq_ctrl (N_ADC=4, N_BITS=4, FIFO_DEPTH=2).
// Expected results go into a scoreboard queue when a conversion is started.
// They are popped and compared whenever the FIFO head is handed over.
module tb_adc_seq_ctrl;
    localparam int N_ADC = 4, N_BITS = 4, CNT_W = 8, FIFO_DEPTH = 2, CH_W = 2;

    logic             clk = 1'b0, rst = 1'b1;
    logic [CNT_W-1:0] cfg_t_init, cfg_t_samp, cfg_t_comp, cfg_t_update;
    logic [N_ADC-1:0] cfg_en, comp_in;
    logic             cfg_mode, start, abort, res_ready;
    logic             seq_init, seq_samp, seq_cmp, seq_logic, busy, done, res_valid;
    logic [CH_W-1:0]  res_chan;
    logic [N_BITS-1:0] res_data;

    int checks = 0, errors = 0;
    logic [N_ADC-1:0] dec [4];           // dec[b] = comp_in vector for decision b
    int bitidx = 0;
    logic [CH_W+N_BITS-1:0] sbq [$];
    logic [CH_W+N_BITS-1:0] exp_e;

    adc_seq_ctrl #(.N_ADC(N_ADC), .N_BITS(N_BITS), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cfg_t_init(cfg_t_init), .cfg_t_samp(cfg_t_samp),
        .cfg_t_comp(cfg_t_comp), .cfg_t_update(cfg_t_update),
        .cfg_en(cfg_en), .cfg_mode(cfg_mode), .start(start), .abort(abort),
        .comp_in(comp_in),
        .seq_init(seq_init), .seq_samp(seq_samp), .seq_cmp(seq_cmp), .seq_logic(seq_logic),
        .busy(busy), .done(done), .res_valid(res_valid), .res_ready(res_ready),
        .res_chan(res_chan), .res_data(res_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decision word that channel ch should hold, first decision in the MSB.
    function automatic logic [N_BITS-1:0] word_of(input int ch);
        logic [N_BITS-1:0] w;
        w = '0;
        for (int b = 0; b < N_BITS; b++) w = {w[N_BITS-2:0], dec[b][ch]};
        return w;
    endfunction

    task automatic push_exp(input int ch, input logic [N_BITS-1:0] w);
        sbq.push_back({CH_W'(ch), w});
    endtask

    task automatic wait_done(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int n = 0; n < max_cyc && !seen; n++) begin
            if (done) seen = 1'b1;
            else tick();
        end
    endtask

    // Every COMP phase in this bench lasts one cycle: present decision
    // bitidx during it, advance after it.
    always @(posedge clk) begin
        if (seq_init)     bitidx = 0;
        else if (seq_cmp) bitidx = bitidx + 1;
    end
    always @(negedge clk) comp_in = seq_cmp ? dec[bitidx % 4] : '0;

    // Scoreboard consumer: a handover happens on the edge after this sample.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            checks++;
            assert (sbq.size() > 0) else begin
                errors++;
                $error("FAIL sb_unexpected: observed chan %0d data 0x%0h expected no entry", res_chan, res_data);
            end
            if (sbq.size() > 0) begin
                exp_e = sbq.pop_front();
                chk("sb_entry", 32'({res_chan, res_data}), 32'(exp_e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        int dcnt;
        logic [3:0] codes [1:21];
        cfg_t_init = 8'd1; cfg_t_samp = 8'd1; cfg_t_comp = 8'd1; cfg_t_update = 8'd1;
        cfg_en = 4'b0101; cfg_mode = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
        for (int b = 0; b < 4; b++) dec[b] = '0;
        tick(); tick();
        chk("rst_outputs", 32'({seq_init, seq_samp, seq_cmp, seq_logic, busy, done, res_valid}), 32'd0);
        chk("rst_chan", 32'(res_chan), 32'd0);
        chk("rst_data", 32'(res_data), 32'd0);
        rst = 1'b0;
        tick();

        // 1: reset asserted during COMP clears everything at once
        start = 1'b1; tick(); start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            if (seq_cmp) seen = 1'b1;
            else tick();
        end
        chk("t1_reach_comp", 32'(seen), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("t1_async_rst", 32'({seq_init, seq_samp, seq_cmp, seq_logic, busy, done, res_valid}), 32'd0);
        chk("t1_async_data", 32'({res_chan, res_data}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        tick();

        // 2: single conversion, ch0 = 1,0,1,1 and ch2 = 0,1,1,0
        dec[0] = 4'b1011; dec[1] = 4'b1110; dec[2] = 4'b0101; dec[3] = 4'b1001;
        push_exp(0, 4'hB); push_exp(2, 4'h6);
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            chk("t2_busy", 32'(busy), (c <= 14) ? 32'd1 : 32'd0);
            chk("t2_done", 32'(done), (c == 14) ? 32'd1 : 32'd0);
            if (c == 1)  chk("t2_init", 32'({seq_init, seq_samp, seq_cmp, seq_logic}), 32'h8);
            if (c == 12) chk("t2_head", 32'({res_valid, res_chan, res_data}), 32'({1'b1, 2'd0, 4'hB}));
            tick();
        end
        chk("t2_sb_empty", 32'(sbq.size()), 32'd0);

        // 3: backpressure, all channels, consumer stalled
        cfg_en = 4'b1111; res_ready = 1'b0;
        dec[0] = 4'b1010; dec[1] = 4'b0110; dec[2] = 4'b1111; dec[3] = 4'b0001;
        for (int ch = 0; ch < 4; ch++) push_exp(ch, word_of(ch));
        start = 1'b1; tick(); start = 1'b0;
        dcnt = 0;
        for (int c = 1; c <= 20; c++) begin
            if (done) dcnt++;
            tick();
        end
        chk("t3_no_done", 32'(dcnt), 32'd0);
        chk("t3_stall_busy", 32'({busy, res_valid}), 32'h3);
        chk("t3_stall_strobes", 32'({seq_init, seq_samp, seq_cmp, seq_logic}), 32'd0);
        res_ready = 1'b1;
        wait_done(12, seen);
        chk("t3_done", 32'(seen), 32'd1);
        tick();
        chk("t3_idle", 32'(busy), 32'd0);
        tick(); tick(); tick();
        chk("t3_sb_empty", 32'(sbq.size()), 32'd0);

        // 4: phase lengths 3/2/0/2 on ch0 only
        cfg_t_init = 8'd3; cfg_t_samp = 8'd2; cfg_t_comp = 8'd0; cfg_t_update = 8'd2;
        cfg_en = 4'b0001;
        dec[0] = 4'b1110; dec[1] = 4'b0001; dec[2] = 4'b0000; dec[3] = 4'b1010;
        push_exp(0, 4'h4);
        for (int c = 1; c <= 21; c++) codes[c] = 4'b0000;
        for (int c = 1; c <= 3; c++) codes[c] = 4'b1000;
        for (int c = 4; c <= 5; c++) codes[c] = 4'b0100;
        for (int b = 0; b < 4; b++) begin
            codes[6 + 3*b] = 4'b0010;
            codes[7 + 3*b] = 4'b0001;
            codes[8 + 3*b] = 4'b0001;
        end
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            chk("t4_strobes", 32'({seq_init, seq_samp, seq_cmp, seq_logic}), 32'(codes[c]));
            chk("t4_done", 32'(done), (c == 21) ? 32'd1 : 32'd0);
            tick();
        end
        chk("t4_idle", 32'(busy), 32'd0);
        tick(); tick();
        chk("t4_sb_empty", 32'(sbq.size()), 32'd0);

        // 5: fill FIFO with two results, then abort a run during SAMP
        cfg_t_init = 8'd1; cfg_t_samp = 8'd1; cfg_t_comp = 8'd1; cfg_t_update = 8'd1;
        cfg_en = 4'b0011; res_ready = 1'b0;
        dec[0] = 4'b0011; dec[1] = 4'b0010; dec[2] = 4'b0001; dec[3] = 4'b0011;
        push_exp(0, word_of(0)); push_exp(1, word_of(1));
        start = 1'b1; tick(); start = 1'b0;
        wait_done(20, seen);
        chk("t5_fill_done", 32'(seen), 32'd1);
        tick();
        cfg_t_samp = 8'd3;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("t5_in_samp", 32'({seq_init, seq_samp, seq_cmp, seq_logic}), 32'h4);
        abort = 1'b1;
        chk("t5_no_done", 32'(done), 32'd0);
        tick();
        abort = 1'b0;
        chk("t5_abort_state", 32'({seq_init, seq_samp, seq_cmp, seq_logic, busy, done}), 32'd0);
        tick(); tick(); tick();
        chk("t5_fifo_kept", 32'({busy, res_valid, res_chan}), 32'({1'b0, 1'b1, 2'd0}));
        res_ready = 1'b1;
        tick(); tick(); tick(); tick();
        chk("t5_sb_empty", 32'(sbq.size()), 32'd0);
        chk("t5_fifo_empty", 32'(res_valid), 32'd0);

        // 6: continuous mode, stray start while busy, mode cleared mid-run
        cfg_t_samp = 8'd1; cfg_en = 4'b0101; cfg_mode = 1'b1;
        dec[0] = 4'b1011; dec[1] = 4'b1110; dec[2] = 4'b0101; dec[3] = 4'b1001;
        for (int r = 0; r < 2; r++) begin
            push_exp(0, 4'hB); push_exp(2, 4'h6);
        end
        start = 1'b1; tick(); start = 1'b0;
        dcnt = 0;
        for (int c = 1; c <= 32; c++) begin
            if (c == 3)  start = 1'b1;
            if (c == 4)  start = 1'b0;
            if (c == 18) cfg_mode = 1'b0;
            if (done) dcnt++;
            chk("t6_done", 32'(done), (c == 14 || c == 28) ? 32'd1 : 32'd0);
            if (c == 15) chk("t6_restart", 32'({busy, seq_init}), 32'h3);
            if (c == 29) chk("t6_stop", 32'(busy), 32'd0);
            tick();
        end
        chk("t6_done_count", 32'(dcnt), 32'd2);
        chk("t6_sb_empty", 32'(sbq.size()), 32'd0);
        chk("t6_idle", 32'({busy, res_valid}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
